// File: rtl/data_selector_pkg.sv
// data_selector_pkg: shared types and constants for the data selector bank.
//   cmd_e   : command decode of {read_sig_i, write_sig_i}
//   state_e : bank control FSM states
//   ERRCNT_W/ERRCNT_MAX : illegal-command counter width and saturation value
package data_selector_pkg;

  typedef enum logic [1:0] {
    CMD_NOP = 2'b00,
    CMD_RD  = 2'b01,
    CMD_WR  = 2'b10,
    CMD_ILL = 2'b11
  } cmd_e;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int unsigned ERRCNT_W   = 8;
  localparam int unsigned ERRCNT_MAX = 255;

endpackage : data_selector_pkg

// File: rtl/ds_regbank.sv
// ds_regbank: DEPTH x DATA_W register storage.
// Ports:
//   clk_i, rst_i      : clock, asynchronous active-high clear of all cells
//   we_i/wadr_i/wdata_i : synchronous write port
//   radr_i/rdata_c    : combinational read port
module ds_regbank #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADR_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADR_W-1:0]  wadr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADR_W-1:0]  radr_i,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Next-state of the storage: single write port.
  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      mem_d[wadr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // DEPTH is a power of two, so every radr_i value is a valid index.
  assign rdata_c = mem_q[radr_i];

endmodule : ds_regbank

// File: rtl/data_selector_bank.sv
// data_selector_bank: DEPTH-entry scratch register bank with valid/ready command
// handshake, single and auto-incrementing burst reads, writes and a sticky
// illegal-command error flag.
// Optional feature: define DS_ERRCNT_EN to build the saturating 8-bit
// illegal-command counter on err_cnt_o; otherwise err_cnt_o is tied to 0.
// Ports:
//   clk_i, rst_i              : clock, asynchronous active-high reset
//   req_valid_i, req_ready_o  : command handshake (ready only in IDLE)
//   read_sig_i, write_sig_i   : command bits {read_sig_i, write_sig_i}
//   adr_i, burst_len_i, data_i: address, extra read beats, write data
//   err_clr_i                 : clears err_o (and err_cnt_o)
//   data_o, data_valid_o      : registered read data and beat strobe
//   busy_o                    : burst in progress
//   err_o, err_cnt_o          : sticky illegal flag, illegal-command count
module data_selector_bank
  import data_selector_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADR_W  = $clog2(DEPTH),
  parameter int unsigned LEN_W  = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                read_sig_i,
  input  logic                write_sig_i,
  input  logic [ADR_W-1:0]    adr_i,
  input  logic [LEN_W-1:0]    burst_len_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic                err_clr_i,
  output logic [DATA_W-1:0]   data_o,
  output logic                data_valid_o,
  output logic                busy_o,
  output logic                err_o,
  output logic [ERRCNT_W-1:0] err_cnt_o
);

  state_e            state_q, state_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  cmd_e              cmd_c;
  logic              accept_c;
  logic              we_c;
  logic              ill_c;
  logic [ADR_W-1:0]  rd_adr_c;
  logic [DATA_W-1:0] rd_data_c;

  ds_regbank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADR_W  (ADR_W)
  ) u_regbank (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (we_c),
    .wadr_i  (adr_i),
    .wdata_i (data_i),
    .radr_i  (rd_adr_c),
    .rdata_c (rd_data_c)
  );

  // Command decode, burst sequencing and output next-state.
  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    len_d    = len_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    we_c     = 1'b0;
    ill_c    = 1'b0;
    rd_adr_c = adr_i;
    cmd_c    = cmd_e'({read_sig_i, write_sig_i});
    accept_c = req_valid_i && (state_q == IDLE);

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          unique case (cmd_c)
            CMD_NOP: begin
              data_d = '0;
            end
            CMD_RD: begin
              data_d  = rd_data_c;
              valid_d = 1'b1;
              if (burst_len_i != '0) begin
                // Beat 0 goes out now; counter holds the beats still owed.
                state_d = BURST;
                adr_d   = adr_i + ADR_W'(1);
                len_d   = burst_len_i;
              end
            end
            CMD_WR: begin
              we_c   = 1'b1;
              data_d = '0;
            end
            CMD_ILL: begin
              ill_c  = 1'b1;
              data_d = '1;
            end
            default: ;
          endcase
        end
      end
      BURST: begin
        rd_adr_c = adr_q;
        data_d   = rd_data_c;
        valid_d  = 1'b1;
        adr_d    = adr_q + ADR_W'(1);
        len_d    = len_q - LEN_W'(1);
        if (len_q == LEN_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == BURST);
    // Set beats clear when both happen in the same cycle.
    err_d  = (err_q && !err_clr_i) || ill_c;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      adr_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      len_q   <= len_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

`ifdef DS_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating illegal-command counter; a clear with a coincident illegal leaves 1.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr_i) begin
      err_cnt_d = '0;
    end
    if (ill_c) begin
      if (err_clr_i) begin
        err_cnt_d = ERRCNT_W'(1);
      end else if (err_cnt_q != ERRCNT_W'(ERRCNT_MAX)) begin
        err_cnt_d = err_cnt_q + ERRCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = '0;
`endif

  assign req_ready_o  = !rst_i && (state_q == IDLE);
  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;

endmodule : data_selector_bank

// File: tb/tb_data_selector_bank.sv
// Self-checking bench for data_selector_bank (DEPTH=4, DATA_W=8).
// A behavioural model predicts each cycle's outputs when stimulus is applied;
// predictions queue up and are compared on the following falling edge.
module tb_data_selector_bank;

`ifdef DS_ERRCNT_EN
  localparam bit ERRCNT_ON = 1'b1;
`else
  localparam bit ERRCNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_i;
  logic       req_valid_i;
  logic       req_ready_o;
  logic       read_sig_i;
  logic       write_sig_i;
  logic [1:0] adr_i;
  logic [3:0] burst_len_i;
  logic [7:0] data_i;
  logic       err_clr_i;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       busy_o;
  logic       err_o;
  logic [7:0] err_cnt_o;

  data_selector_bank dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .read_sig_i   (read_sig_i),
    .write_sig_i  (write_sig_i),
    .adr_i        (adr_i),
    .burst_len_i  (burst_len_i),
    .data_i       (data_i),
    .err_clr_i    (err_clr_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .busy_o       (busy_o),
    .err_o        (err_o),
    .err_cnt_o    (err_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] m_mem [4];
  int         pend[$];
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_err;
  int         m_cnt;

  localparam logic [1:0] NOP = 2'b00, RD = 2'b01, WR = 2'b10, ILL = 2'b11;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_mem[i] = 8'h00;
    pend.delete();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_cnt   = 0;
  endtask

  // Apply one cycle of stimulus, then predict the registered outputs.
  task automatic step(input bit v, input logic [1:0] cmd, input int adr, input int len,
                      input logic [7:0] din, input bit clr);
    bit acc;
    exp_t e;
    @(negedge clk);
    #1;
    req_valid_i = v;
    {read_sig_i, write_sig_i} = cmd;
    adr_i       = 2'(adr);
    burst_len_i = 4'(len);
    data_i      = din;
    err_clr_i   = clr;
    check_eq("req_ready_o", 32'(req_ready_o), 32'(pend.size() == 0));
    @(posedge clk);
    acc = v && (pend.size() == 0);
    if (clr) begin
      m_err = 1'b0;
      m_cnt = 0;
    end
    if (pend.size() > 0) begin
      int a;
      a = pend.pop_front();
      m_data  = m_mem[a];
      m_valid = 1'b1;
    end else if (acc) begin
      case (cmd)
        NOP: begin m_data = 8'h00; m_valid = 1'b0; end
        RD: begin
          m_data  = m_mem[adr];
          m_valid = 1'b1;
          for (int k = 1; k <= len; k++) pend.push_back((adr + k) % 4);
        end
        WR: begin m_mem[adr] = din; m_data = 8'h00; m_valid = 1'b0; end
        default: begin
          m_data  = 8'hFF;
          m_valid = 1'b0;
          m_err   = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
      endcase
    end else begin
      m_valid = 1'b0;
    end
    e.data  = m_data;
    e.valid = m_valid;
    e.busy  = (pend.size() > 0);
    e.err   = m_err;
    e.cnt   = ERRCNT_ON ? 8'(m_cnt) : 8'h00;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, NOP, 0, 0, 8'h00, 1'b0);
  endtask

  // Scoreboard: compare the oldest prediction against the DUT outputs.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_eq("data_o",       32'(data_o),       32'(e.data));
      check_eq("data_valid_o", 32'(data_valid_o), 32'(e.valid));
      check_eq("busy_o",       32'(busy_o),       32'(e.busy));
      check_eq("err_o",        32'(err_o),        32'(e.err));
      check_eq("err_cnt_o",    32'(err_cnt_o),    32'(e.cnt));
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_data_o"},   32'(data_o),       32'h0);
    check_eq({tag, "_valid"},    32'(data_valid_o), 32'h0);
    check_eq({tag, "_busy"},     32'(busy_o),       32'h0);
    check_eq({tag, "_err"},      32'(err_o),        32'h0);
    check_eq({tag, "_err_cnt"},  32'(err_cnt_o),    32'h0);
    check_eq({tag, "_ready"},    32'(req_ready_o),  32'h0);
  endtask

  initial begin
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    read_sig_i  = 1'b0;
    write_sig_i = 1'b0;
    adr_i       = 2'd0;
    burst_len_i = 4'd0;
    data_i      = 8'h00;
    err_clr_i   = 1'b0;
    model_reset();

    // Reset state
    #3;
    check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    #1 rst_i = 1'b0;

    // Writes, single reads, NOP after read, idle hold
    step(1'b1, WR, 0, 0, 8'hA5, 1'b0);
    step(1'b1, WR, 3, 0, 8'h3C, 1'b0);
    step(1'b1, RD, 0, 0, 8'h00, 1'b0);
    step(1'b1, RD, 3, 0, 8'h00, 1'b0);
    idle(2);
    step(1'b1, RD, 0, 0, 8'h00, 1'b0);
    step(1'b1, NOP, 0, 0, 8'h00, 1'b0);
    step(1'b0, WR, 1, 0, 8'h77, 1'b0);
    step(1'b1, RD, 1, 0, 8'h00, 1'b0);

    // Wrapping burst with a write request held during the burst
    for (int i = 0; i < 4; i++) step(1'b1, WR, i, 0, 8'(8'h10 + i), 1'b0);
    step(1'b1, RD, 2, 3, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, WR, 0, 0, 8'hEE, 1'b0);
    idle(1);
    step(1'b1, RD, 0, 0, 8'h00, 1'b0);
    step(1'b1, RD, 3, 15, 8'h00, 1'b0);
    idle(16);

    // Illegal command, sticky error, clear, counter
    step(1'b1, ILL, 1, 0, 8'h55, 1'b0);
    step(1'b1, NOP, 0, 0, 8'h00, 1'b0);
    step(1'b1, RD, 1, 0, 8'h00, 1'b0);
    step(1'b0, NOP, 0, 0, 8'h00, 1'b1);
    idle(1);
    for (int i = 0; i < 3; i++) step(1'b1, ILL, 0, 0, 8'h00, 1'b0);
    idle(1);
    step(1'b0, NOP, 0, 0, 8'h00, 1'b1);
    for (int i = 0; i < 260; i++) step(1'b1, ILL, i % 4, 0, 8'h00, 1'b0);
    idle(1);
    step(1'b1, ILL, 0, 0, 8'h00, 1'b1);
    idle(1);
    step(1'b0, NOP, 0, 0, 8'h00, 1'b1);

    // Asynchronous reset in the middle of a burst, after two beats
    step(1'b1, RD, 0, 3, 8'h00, 1'b0);
    idle(1);
    @(negedge clk);
    #2 rst_i = 1'b1;
    #1;
    check_reset_outputs("mid_burst_rst");
    sb.delete();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1 rst_i = 1'b0;
    idle(3);
    for (int i = 0; i < 4; i++) step(1'b1, RD, i, 0, 8'h00, 1'b0);
    idle(2);

    // Drain outstanding predictions, bounded
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d predictions left, expected 0", sb.size());
    end
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_data_selector_bank
